// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - shared types and signature update for the CPU run monitor
package mon_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_HALT    = 2'd1,
    STAT_HANG    = 2'd2,
    STAT_TIMEOUT = 2'd3
  } status_e;

  localparam int unsigned SIG_MAX_W = 64;
  typedef logic [SIG_MAX_W-1:0] sig_word_t;

  // Rotate-left-by-one within the low w bits, then fold in data and register index.
  function automatic sig_word_t sig_update(sig_word_t sig, sig_word_t data,
                                           logic [4:0] rd, int unsigned w);
    sig_word_t mask;
    sig_word_t rot;
    mask = {SIG_MAX_W{1'b1}} >> (SIG_MAX_W - w);
    rot  = ((sig << 1) | (sig >> (w - 1))) & mask;
    return (rot ^ data ^ sig_word_t'(rd)) & mask;
  endfunction

endpackage

// File: rtl/sig_accum.sv
// rtl/sig_accum.sv - signature register folding one write per enabled cycle
module sig_accum
  import mon_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  input  logic [4:0]   reg_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (en_i) sig_d = W'(sig_update(sig_word_t'(sig_q), sig_word_t'(data_i), reg_i, W));
  end

  always_ff @(posedge clk) begin
    if (clr_i) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - CPU reset sequencing, run counters and halt/hang/timeout detection
module cpu_run_monitor
  import mon_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned STALL_LIMIT  = 64,
  parameter int unsigned HALT_REPEAT  = 3,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              wb_we,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              cpu_reset,
  output logic              run_en,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [DATA_W-1:0] signature
);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              run_en_q, run_en_d;
  logic              done_q, done_d;
  logic              halt, hang, tmo, sig_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      status_q    <= STAT_NONE;
      hold_cnt_q  <= '0;
      cycle_q     <= '0;
      retire_q    <= '0;
      idle_q      <= '0;
      rep_q       <= '0;
      last_pc_q   <= '0;
      cpu_reset_q <= 1'b1;
      run_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      idle_q      <= idle_d;
      rep_q       <= rep_d;
      last_pc_q   <= last_pc_d;
      cpu_reset_q <= cpu_reset_d;
      run_en_q    <= run_en_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    hold_cnt_d = hold_cnt_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    idle_d     = idle_q;
    rep_d      = rep_q;
    last_pc_d  = last_pc_q;
    halt       = 1'b0;
    hang       = 1'b0;
    tmo        = 1'b0;
    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        if (hold_cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (wb_valid) begin
          retire_d  = retire_q + CNT_W'(1);
          last_pc_d = wb_pc;
          rep_d     = (wb_pc == last_pc_q && rep_q != '0) ? rep_q + CNT_W'(1) : CNT_W'(1);
          idle_d    = '0;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
        halt = wb_valid && (rep_d == CNT_W'(HALT_REPEAT));
        hang = !wb_valid && (idle_d == CNT_W'(STALL_LIMIT));
        tmo  = (cycle_d == CNT_W'(MAX_CYCLES));
        if (halt || hang || tmo) begin
          state_d  = ST_DONE;
          status_d = halt ? STAT_HALT : (hang ? STAT_HANG : STAT_TIMEOUT);
        end
      end
      default: ;
    endcase
  end

  // Control outputs are registered copies of the decoded next state.
  always_comb begin
    cpu_reset_d = (state_d == ST_HOLD);
    run_en_d    = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  assign sig_en = (state_q == ST_RUN) && wb_valid && wb_we && (wb_reg != 5'd0);

  sig_accum #(.W(DATA_W)) u_sig (
    .clk    (clk),
    .clr_i  (reset),
    .en_i   (sig_en),
    .data_i (wb_data),
    .reg_i  (wb_reg),
    .sig_o  (signature)
  );

  assign cpu_reset    = cpu_reset_q;
  assign run_en       = run_en_q;
  assign done         = done_q;
  assign status       = status_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule
